// File: rtl/arriskv_pkg.sv
// arriskv_pkg: shared decode types and encoding constants for the arriskv core.
//   instr_t      - decoded operation, INSTR_ILLEGAL marks unsupported words
//   instr_type_t - instruction format (R/I/S/B/U/J)
//   OPC_*/F3_*/F7_* - opcode, funct3 and funct7 field values
package arriskv_pkg;

  typedef enum logic [3:0] {
    INSTR_ADDI,
    INSTR_SLTI,
    INSTR_SLTIU,
    INSTR_XORI,
    INSTR_ORI,
    INSTR_ANDI,
    INSTR_SLLI,
    INSTR_SRLI,
    INSTR_SRAI,
    INSTR_ADD,
    INSTR_LUI,
    INSTR_AUIPC,
    INSTR_ILLEGAL
  } instr_t;

  typedef enum logic [2:0] {
    R_TYPE,
    I_TYPE,
    S_TYPE,
    B_TYPE,
    U_TYPE,
    J_TYPE
  } instr_type_t;

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

endpackage

// File: rtl/instr_decoder.sv
// instr_decoder: purely combinational instruction word decode.
//   word       in  raw 32-bit instruction
//   instr      out decoded operation (INSTR_ILLEGAL if unsupported)
//   instr_type out format of the operation
//   rs1/rs2/rd out register fields of the word
//   rs1_used   out operation reads rs1
//   rs2_used   out operation reads rs2
//   imm        out raw immediate field (I: word[31:20], U: word[31:12])
//   illegal    out unsupported encoding
module instr_decoder
  import arriskv_pkg::*;
(
  input  logic [31:0]  word,
  output instr_t       instr,
  output instr_type_t  instr_type,
  output logic [4:0]   rs1,
  output logic [4:0]   rs2,
  output logic [4:0]   rd,
  output logic         rs1_used,
  output logic         rs2_used,
  output logic [19:0]  imm,
  output logic         illegal
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;

  assign opcode = word[6:0];
  assign funct3 = word[14:12];
  assign funct7 = word[31:25];
  assign rs1    = word[19:15];
  assign rs2    = word[24:20];
  assign rd     = word[11:7];

  always_comb begin
    instr      = INSTR_ILLEGAL;
    instr_type = R_TYPE;
    rs1_used   = 1'b0;
    rs2_used   = 1'b0;
    imm        = '0;
    illegal    = 1'b0;

    case (opcode)
      OPC_OP_IMM: begin
        instr_type = I_TYPE;
        rs1_used   = 1'b1;
        imm        = {8'b0, word[31:20]};
        case (funct3)
          F3_ADD:  instr = INSTR_ADDI;
          F3_SLT:  instr = INSTR_SLTI;
          F3_SLTU: instr = INSTR_SLTIU;
          F3_XOR:  instr = INSTR_XORI;
          F3_OR:   instr = INSTR_ORI;
          F3_AND:  instr = INSTR_ANDI;
          F3_SLL:  if (funct7 == F7_ZERO) instr = INSTR_SLLI;
          F3_SR: begin
            if (funct7 == F7_ZERO)     instr = INSTR_SRLI;
            else if (funct7 == F7_ALT) instr = INSTR_SRAI;
          end
          default: instr = INSTR_ILLEGAL;
        endcase
      end
      OPC_OP: begin
        instr_type = R_TYPE;
        rs1_used   = 1'b1;
        rs2_used   = 1'b1;
        if (funct3 == F3_ADD && funct7 == F7_ZERO) instr = INSTR_ADD;
      end
      OPC_LUI: begin
        instr      = INSTR_LUI;
        instr_type = U_TYPE;
        imm        = word[31:12];
      end
      OPC_AUIPC: begin
        instr      = INSTR_AUIPC;
        instr_type = U_TYPE;
        imm        = word[31:12];
      end
      default: instr = INSTR_ILLEGAL;
    endcase

    // Unsupported sub-encodings of a known opcode fall back to a clean
    // illegal decode so they neither read registers nor stall on hazards.
    if (instr == INSTR_ILLEGAL) begin
      illegal    = 1'b1;
      instr_type = R_TYPE;
      rs1_used   = 1'b0;
      rs2_used   = 1'b0;
      imm        = '0;
    end
  end

endmodule

// File: rtl/decode_issue.sv
// decode_issue: decode/issue stage feeding the ALU.
//   clk, rst_n               clock, asynchronous active-low reset
//   i_valid/o_ready          fetch handshake, i_instr_word + i_pc
//   o_rs1_addr/o_rs2_addr    register file read addresses
//   i_rs1_data/i_rs2_data    combinational register file read data
//   i_wb_valid/i_wb_rd       writeback clears the pending bit of i_wb_rd
//   i_flush                  kill the held issue bundle
//   o_valid/i_ready          issue handshake to the ALU
//   o_pc/o_arg1/o_arg2/o_instr/o_instr_type/o_rd/o_illegal  registered bundle
module decode_issue
  import arriskv_pkg::*;
#(
  parameter int wd_regs_p = 32,
  parameter int n_regs_p  = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [31:0]          i_instr_word,
  input  logic [wd_regs_p-1:0] i_pc,
  output logic [4:0]           o_rs1_addr,
  output logic [4:0]           o_rs2_addr,
  input  logic [wd_regs_p-1:0] i_rs1_data,
  input  logic [wd_regs_p-1:0] i_rs2_data,
  input  logic                 i_wb_valid,
  input  logic [4:0]           i_wb_rd,
  input  logic                 i_flush,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [wd_regs_p-1:0] o_pc,
  output logic [wd_regs_p-1:0] o_arg1,
  output logic [wd_regs_p-1:0] o_arg2,
  output instr_t               o_instr,
  output instr_type_t          o_instr_type,
  output logic [4:0]           o_rd,
  output logic                 o_illegal
);

  instr_t      dec_instr;
  instr_type_t dec_type;
  logic [4:0]  dec_rs1;
  logic [4:0]  dec_rs2;
  logic [4:0]  dec_rd;
  logic        dec_rs1_used;
  logic        dec_rs2_used;
  logic [19:0] dec_imm;
  logic        dec_illegal;

  instr_decoder u_dec (
    .word       (i_instr_word),
    .instr      (dec_instr),
    .instr_type (dec_type),
    .rs1        (dec_rs1),
    .rs2        (dec_rs2),
    .rd         (dec_rd),
    .rs1_used   (dec_rs1_used),
    .rs2_used   (dec_rs2_used),
    .imm        (dec_imm),
    .illegal    (dec_illegal)
  );

  assign o_rs1_addr = dec_rs1;
  assign o_rs2_addr = dec_rs2;

  logic [n_regs_p-1:0]  mask_reg;
  logic [n_regs_p-1:0]  mask_next;
  logic                 hazard;
  logic                 advance;
  logic                 xfer;
  logic                 kill;
  logic                 set_en;
  logic [wd_regs_p-1:0] arg1_next;
  logic [wd_regs_p-1:0] arg2_next;
  logic [wd_regs_p-1:0] imm_ext;

  // Hazard looks at the registered mask only: a writeback retiring this
  // cycle unblocks the consumer on the following cycle.
  assign hazard  = (dec_rs1_used && mask_reg[dec_rs1]) ||
                   (dec_rs2_used && mask_reg[dec_rs2]);
  assign advance = !hazard && (!o_valid || i_ready);
  assign o_ready = advance && !i_flush;
  assign xfer    = i_valid && o_ready;
  assign set_en  = xfer && !dec_illegal && (dec_rd != 5'd0);

  // A flushed bundle that was not consumed will never write back, so its
  // pending bit is released here. Illegal bundles never set one.
  assign kill = i_flush && o_valid && !i_ready && !o_illegal;

  assign imm_ext = {{(wd_regs_p-20){1'b0}}, dec_imm};

  always_comb begin
    arg1_next = '0;
    if (dec_rs1_used && dec_rs1 != 5'd0) arg1_next = i_rs1_data;
  end

  always_comb begin
    arg2_next = '0;
    case (dec_type)
      R_TYPE:  if (dec_rs2_used && dec_rs2 != 5'd0) arg2_next = i_rs2_data;
      I_TYPE:  arg2_next = imm_ext;
      U_TYPE:  arg2_next = imm_ext;
      default: arg2_next = '0;
    endcase
  end

  // Per-register pending bits; set beats clear when both hit the same rd.
  generate
    for (genvar gi = 0; gi < n_regs_p; gi++) begin : g_mask
      if (gi == 0) begin : g_x0
        assign mask_next[gi] = 1'b0;
      end else begin : g_xn
        logic set_bit;
        logic clr_bit;
        assign set_bit = set_en && (dec_rd == 5'(gi));
        assign clr_bit = (i_wb_valid && (i_wb_rd == 5'(gi))) ||
                         (kill && (o_rd == 5'(gi)));
        assign mask_next[gi] = set_bit || (mask_reg[gi] && !clr_bit);
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask_reg <= '0;
    end else begin
      mask_reg <= mask_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_valid      <= 1'b0;
      o_pc         <= '0;
      o_arg1       <= '0;
      o_arg2       <= '0;
      o_instr      <= INSTR_ILLEGAL;
      o_instr_type <= R_TYPE;
      o_rd         <= '0;
      o_illegal    <= 1'b0;
    end else if (xfer) begin
      o_valid      <= 1'b1;
      o_pc         <= i_pc;
      o_arg1       <= arg1_next;
      o_arg2       <= arg2_next;
      o_instr      <= dec_instr;
      o_instr_type <= dec_type;
      o_rd         <= dec_rd;
      o_illegal    <= dec_illegal;
    end else if (i_flush || (o_valid && i_ready)) begin
      o_valid <= 1'b0;
    end
  end

endmodule
